// File: rtl/control_sequencer_if.sv
// Datapath-facing signals of the control sequencer: instruction and memory
// handshake in, bus-enable / register-load strobes and status out.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;

    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        Zhighout;
    logic        Zlowout;
    logic        HIin;
    logic        LOin;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic [4:0]  opcode;
    logic        Run;
    logic        Mem_fault;
    logic        Illegal;

    modport master (
        output IR, Mem_ready, Stop,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, Gra, Grb, Grc,
               Rin, Rout, opcode, Run, Mem_fault, Illegal
    );

    modport slave (
        input  IR, Mem_ready, Stop,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, Gra, Grb, Grc,
               Rin, Rout, opcode, Run, Mem_fault, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches, decodes IR[31:27] and issues one datapath
// control step per clock for R-format ALU, mul/div and neg/not instructions.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_RESET | held in reset, all outputs 0
//  S_T0    | PC -> MAR, PC incremented
//  S_T1    | memory read, waiting on Mem_ready (bounded by MEM_WAIT_MAX)
//  S_T2    | MDR -> IR, instruction class decoded
//  S_T3    | first execute step (operand into Y, or neg/not ALU op)
//  S_T4    | ALU op (R, mul/div) or neg/not writeback
//  S_T5    | R-format writeback, or LO load for mul/div
//  S_T6    | HI load for mul/div
//  S_HALT  | stopped; only reset leaves
module control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    control_sequencer_if.slave  bus
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_MD, C_NN, C_NOP, C_HALT, C_ILL
    } cls_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zhigh_out;
        logic zlow_out;
        logic hi_in;
        logic lo_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic run;
    } strobe_t;

    state_t        state_q, state_d, finish_st;
    cls_t          cls_q, cls_d;
    logic [CW-1:0] cnt_q, cnt_d;
    strobe_t       str_q;
    logic [4:0]    op;
    logic          unused_fields;

    assign op            = bus.IR[31:27];
    assign unused_fields = ^bus.IR[26:0];

    function automatic cls_t decode(input logic [4:0] code);
        if (code >= 5'd3 && code <= 5'd11)     return C_R;
        else if (code == 5'd15 || code == 5'd16) return C_MD;
        else if (code == 5'd17 || code == 5'd18) return C_NN;
        else if (code == 5'd26)                return C_NOP;
        else if (code == 5'd27)                return C_HALT;
        else                                   return C_ILL;
    endfunction

    function automatic strobe_t strobes(input state_t s, input cls_t c);
        strobe_t o;
        o = '0;
        o.run = (s != S_RESET) && (s != S_HALT);
        case (s)
            S_T0: begin
                o.pc_out = 1'b1;
                o.mar_in = 1'b1;
                o.inc_pc = 1'b1;
                o.pc_in  = 1'b1;
            end
            S_T1: begin
                o.read   = 1'b1;
                o.mdr_in = 1'b1;
            end
            S_T2: begin
                o.mdr_out = 1'b1;
                o.ir_in   = 1'b1;
            end
            S_T3: begin
                case (c)
                    C_R:  begin o.grb = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1; end
                    C_MD: begin o.gra = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1; end
                    C_NN: begin o.grb = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (c)
                    C_R:  begin o.grc = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; end
                    C_MD: begin o.grb = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; end
                    C_NN: begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (c)
                    C_R:  begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
                    C_MD: begin o.zlow_out = 1'b1; o.lo_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                o.zhigh_out = 1'b1;
                o.hi_in     = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Stop only matters on the last step of an instruction
    assign finish_st = bus.Stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                cnt_d   = '0;
            end
            S_T1: begin
                if (bus.Mem_ready)          state_d = S_T2;
                else if (cnt_q == WAIT_LAST) state_d = S_HALT;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            S_T2: begin
                cls_d = decode(op);
                case (cls_d)
                    C_R, C_MD, C_NN: state_d = S_T3;
                    C_HALT:          state_d = S_HALT;
                    default:         state_d = finish_st;
                endcase
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (cls_q == C_NN) ? finish_st : S_T5;
            S_T5:    state_d = (cls_q == C_MD) ? S_T6 : finish_st;
            S_T6:    state_d = finish_st;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Strobes are registered from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cls_q   <= C_NOP;
            cnt_q   <= '0;
            str_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            str_q   <= strobes(state_d, cls_d);
        end
    end

    assign bus.PCout     = str_q.pc_out;
    assign bus.MARin     = str_q.mar_in;
    assign bus.IncPC     = str_q.inc_pc;
    assign bus.PCin      = str_q.pc_in;
    assign bus.Read      = str_q.read;
    assign bus.MDRin     = str_q.mdr_in;
    assign bus.MDRout    = str_q.mdr_out;
    assign bus.IRin      = str_q.ir_in;
    assign bus.Yin       = str_q.y_in;
    assign bus.Zin       = str_q.z_in;
    assign bus.Zhighout  = str_q.zhigh_out;
    assign bus.Zlowout   = str_q.zlow_out;
    assign bus.HIin      = str_q.hi_in;
    assign bus.LOin      = str_q.lo_in;
    assign bus.Gra       = str_q.gra;
    assign bus.Grb       = str_q.grb;
    assign bus.Grc       = str_q.grc;
    assign bus.Rin       = str_q.r_in;
    assign bus.Rout      = str_q.r_out;
    assign bus.Run       = str_q.run;
    assign bus.opcode    = str_q.z_in ? op : 5'b00000;
    assign bus.Mem_fault = (state_q == S_T1) && !bus.Mem_ready && (cnt_q == WAIT_LAST);
    assign bus.Illegal   = (state_q == S_T2) && (decode(op) == C_ILL);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected strobe vectors
// are generated from the instruction step tables and compared on the falling edge.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [26:0] PCOUT  = 27'd1 << 26;
    localparam logic [26:0] MARIN  = 27'd1 << 25;
    localparam logic [26:0] INCPC  = 27'd1 << 24;
    localparam logic [26:0] PCIN   = 27'd1 << 23;
    localparam logic [26:0] READ   = 27'd1 << 22;
    localparam logic [26:0] MDRIN  = 27'd1 << 21;
    localparam logic [26:0] MDROUT = 27'd1 << 20;
    localparam logic [26:0] IRIN   = 27'd1 << 19;
    localparam logic [26:0] YIN    = 27'd1 << 18;
    localparam logic [26:0] ZIN    = 27'd1 << 17;
    localparam logic [26:0] ZHIGH  = 27'd1 << 16;
    localparam logic [26:0] ZLOW   = 27'd1 << 15;
    localparam logic [26:0] HIIN   = 27'd1 << 14;
    localparam logic [26:0] LOIN   = 27'd1 << 13;
    localparam logic [26:0] GRA    = 27'd1 << 12;
    localparam logic [26:0] GRB    = 27'd1 << 11;
    localparam logic [26:0] GRC    = 27'd1 << 10;
    localparam logic [26:0] RIN    = 27'd1 << 9;
    localparam logic [26:0] ROUT   = 27'd1 << 8;
    localparam logic [26:0] RUN    = 27'd1 << 7;
    localparam logic [26:0] FAULT  = 27'd1 << 6;
    localparam logic [26:0] ILL    = 27'd1 << 5;

    localparam int K_R = 0, K_MD = 1, K_NN = 2, K_NOP = 3, K_HALT = 4, K_ILL = 5;
    localparam int WAIT_MAX = 15;

    typedef struct {
        logic [31:0] ir;
        bit          ready;
        bit          stop;
        logic [26:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [4:0] run_ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};

    function automatic logic [26:0] observe();
        return {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zhighout, bus.Zlowout,
                bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                bus.Run, bus.Mem_fault, bus.Illegal, bus.opcode};
    endfunction

    function automatic int op_kind(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return K_R;
        if (op == 5'd15 || op == 5'd16) return K_MD;
        if (op == 5'd17 || op == 5'd18) return K_NN;
        if (op == 5'd26) return K_NOP;
        if (op == 5'd27) return K_HALT;
        return K_ILL;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [31:0] ir, input bit rdy, input bit stp,
                                 input logic [26:0] e);
        cyc_t c;
        c.ir = ir; c.ready = rdy; c.stop = stp; c.exp = e;
        q.push_back(c);
    endfunction

    // Expected cycle sequence of one instruction, from fetch to its last step
    task automatic push_instr(input logic [31:0] ir, input int wait_n,
                              input bit stop_final, output bit halts);
        logic [4:0]  op;
        logic [26:0] opv;
        logic [26:0] t2;
        int          kind;
        op   = ir[31:27];
        opv  = 27'(op);
        kind = op_kind(op);
        halts = 1'b0;
        push(ir, rb(), rb(), PCOUT | MARIN | INCPC | PCIN | RUN);
        if (wait_n > WAIT_MAX) begin
            for (int i = 0; i < WAIT_MAX; i++) push(ir, 1'b0, rb(), READ | MDRIN | RUN);
            push(ir, 1'b0, rb(), READ | MDRIN | RUN | FAULT);
            halts = 1'b1;
            return;
        end
        for (int i = 0; i < wait_n; i++) push(ir, 1'b0, rb(), READ | MDRIN | RUN);
        push(ir, 1'b1, rb(), READ | MDRIN | RUN);
        t2 = MDROUT | IRIN | RUN | ((kind == K_ILL) ? ILL : 27'd0);
        case (kind)
            K_R: begin
                push(ir, rb(), rb(), t2);
                push(ir, rb(), rb(), GRB | ROUT | YIN | RUN);
                push(ir, rb(), rb(), GRC | ROUT | ZIN | RUN | opv);
                push(ir, rb(), stop_final, ZLOW | GRA | RIN | RUN);
                halts = stop_final;
            end
            K_MD: begin
                push(ir, rb(), rb(), t2);
                push(ir, rb(), rb(), GRA | ROUT | YIN | RUN);
                push(ir, rb(), rb(), GRB | ROUT | ZIN | RUN | opv);
                push(ir, rb(), rb(), ZLOW | LOIN | RUN);
                push(ir, rb(), stop_final, ZHIGH | HIIN | RUN);
                halts = stop_final;
            end
            K_NN: begin
                push(ir, rb(), rb(), t2);
                push(ir, rb(), rb(), GRB | ROUT | ZIN | RUN | opv);
                push(ir, rb(), stop_final, ZLOW | GRA | RIN | RUN);
                halts = stop_final;
            end
            K_HALT: begin
                push(ir, rb(), rb(), t2);
                halts = 1'b1;
            end
            default: begin
                push(ir, rb(), stop_final, t2);
                halts = stop_final;
            end
        endcase
    endtask

    function automatic void push_halt(input int n);
        for (int i = 0; i < n; i++) push($urandom, rb(), rb(), 27'd0);
    endfunction

    function automatic logic [31:0] rand_ir(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    task automatic run_q(input string name, input int max_n);
        cyc_t        e;
        logic [26:0] got;
        int          k;
        k = 0;
        while (q.size() > 0 && k < max_n) begin
            e = q.pop_front();
            bus.IR = e.ir;
            bus.Mem_ready = e.ready;
            bus.Stop = e.stop;
            @(negedge clk);
            got = observe();
            n_checks++;
            if (got !== e.exp)
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, e.exp);
            else
                n_pass++;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_reset(input string name);
        logic [26:0] got;
        rst_n = 1'b0;
        #1;
        got = observe();
        n_checks++;
        if (got !== 27'd0) $display("FAIL %s reset_async: got %h expected 0", name, got);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        rst_n = 1'b0;
        bus.IR = 32'hF8000000;
        bus.Mem_ready = 1'b0;
        bus.Stop = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = observe();
        n_checks++;
        if (got !== 27'd0) $display("FAIL reset_state: got %h expected 0", got);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        begin
            bit h;
            push_instr(32'h28918000, 0, 1'b0, h);
        end
        run_q("reset_first_fetch", 100000);
    endtask

    task automatic test_rformat();
        bit h;
        do_reset("rformat");
        push_instr(32'h28918000, 0, 1'b0, h);
        for (int i = 0; i < 6; i++)
            push_instr(rand_ir(5'($urandom_range(3, 11))), $urandom_range(0, 3), 1'b0, h);
        run_q("rformat", 100000);
    endtask

    task automatic test_muldiv();
        bit h;
        do_reset("muldiv");
        push_instr(32'h80B80000, 0, 1'b0, h);
        for (int i = 0; i < 4; i++)
            push_instr(rand_ir(rb() ? 5'd15 : 5'd16), $urandom_range(0, 3), 1'b0, h);
        run_q("muldiv", 100000);
    endtask

    task automatic test_negnot();
        bit h;
        do_reset("negnot");
        for (int i = 0; i < 4; i++)
            push_instr(rand_ir(rb() ? 5'd17 : 5'd18), $urandom_range(0, 3), 1'b0, h);
        push_instr(rand_ir(5'd26), 0, 1'b0, h);
        run_q("negnot", 100000);
    endtask

    task automatic test_mem_wait();
        bit h;
        do_reset("mem_wait");
        push_instr(32'h28918000, 3, 1'b0, h);
        push_instr(rand_ir(5'd16), WAIT_MAX, 1'b0, h);
        push_instr(rand_ir(5'd4), $urandom_range(1, 8), 1'b0, h);
        run_q("mem_wait", 100000);
    endtask

    task automatic test_mem_fault();
        bit h;
        do_reset("mem_fault");
        push_instr(rand_ir(5'd3), WAIT_MAX + 1, 1'b0, h);
        push_halt(8);
        run_q("mem_fault", 100000);
    endtask

    task automatic test_stop();
        bit h;
        do_reset("stop_add");
        push_instr(32'h18918000, 0, 1'b1, h);
        push_halt(6);
        run_q("stop_add", 100000);
        do_reset("halt_op");
        push_instr(rand_ir(5'd27), 1, 1'b0, h);
        push_halt(6);
        run_q("halt_op", 100000);
        do_reset("stop_nop");
        push_instr(rand_ir(5'd26), 0, 1'b1, h);
        push_halt(4);
        run_q("stop_nop", 100000);
    endtask

    task automatic test_reset_mid();
        bit          h;
        logic [31:0] ir;
        logic [26:0] got;
        logic [26:0] want;
        do_reset("reset_mid");
        ir = rand_ir(5'd15);
        push_instr(ir, 0, 1'b0, h);
        run_q("reset_mid_pre", 4);
        q.delete();
        want = GRB | ROUT | ZIN | RUN | 27'(ir[31:27]);
        got = observe();
        n_checks++;
        if (got !== want) $display("FAIL reset_mid_t4: got %h expected %h", got, want);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        got = observe();
        n_checks++;
        if (got !== 27'd0) $display("FAIL reset_mid_async: got %h expected 0", got);
        else n_pass++;
        @(posedge clk);
        #1;
        got = observe();
        n_checks++;
        if (got !== 27'd0) $display("FAIL reset_mid_held: got %h expected 0", got);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_instr(32'hF8000000, 0, 1'b0, h);
        push_instr(rand_ir(5'd5), 0, 1'b0, h);
        run_q("reset_mid_restart", 100000);
    endtask

    task automatic test_illegal();
        bit         h;
        logic [4:0] op;
        do_reset("illegal");
        for (int i = 0; i < 5; i++) begin
            do op = 5'($urandom); while (op_kind(op) != K_ILL);
            push_instr(rand_ir(op), $urandom_range(0, 2), 1'b0, h);
        end
        push_instr(rand_ir(5'd18), 0, 1'b0, h);
        run_q("illegal", 100000);
    endtask

    task automatic test_back_to_back();
        bit         h;
        logic [4:0] op;
        do_reset("back_to_back");
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 5'($urandom); while (op_kind(op) != K_ILL);
            end else begin
                op = run_ops[$urandom_range(0, 13)];
            end
            push_instr(rand_ir(op), $urandom_range(0, 5), 1'b0, h);
        end
        push_instr(rand_ir(run_ops[$urandom_range(0, 13)]), $urandom_range(0, 2), 1'b1, h);
        push_halt(4);
        run_q("back_to_back", 100000);
    endtask

    initial begin
        bus.IR = 32'd0;
        bus.Mem_ready = 1'b0;
        bus.Stop = 1'b0;
        test_reset();
        test_rformat();
        test_muldiv();
        test_negnot();
        test_mem_wait();
        test_mem_fault();
        test_stop();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
